// File: rtl/fc_output_quantizer_pkg.sv
// Shared constants and FSM encoding for the FC output quantizer and its requant stage.
package fc_output_quantizer_pkg;
    localparam int ACC_WIDTH  = 32;
    localparam int BIAS_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
    localparam int PACK_NUM   = 20;
    localparam int ADDR_WIDTH = 10;
    localparam int CNT_WIDTH  = 10;
    localparam int SLOT_W     = $clog2(PACK_NUM);
    localparam int Q_MAX      = 2 ** (DATA_WIDTH - 1) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fc_requant.sv
// Two-stage requantizer: S1 adds the bias, S2 applies ReLU, rounding shift and saturation.
module fc_requant
    import fc_output_quantizer_pkg::*;
(
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         in_valid,
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    input  logic [4:0]                   shift,
    output logic                         s1_valid,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        q
);
    localparam int RW = ACC_WIDTH + 2;

    logic signed [ACC_WIDTH:0] s_reg;
    logic signed [RW-1:0]      half;
    logic signed [RW-1:0]      rnd;
    logic signed [RW-1:0]      r;
    logic [DATA_WIDTH-1:0]     q_next;

    // One extra bit of headroom so the rounding add cannot wrap for any legal shift.
    always_comb begin
        half   = '0;
        rnd    = '0;
        r      = '0;
        q_next = '0;
        if (shift != 5'd0) begin
            half = RW'(1) << (shift - 5'd1);
        end
        rnd = {s_reg[ACC_WIDTH], s_reg} + half;
        r   = rnd >>> shift;
        if (s_reg[ACC_WIDTH] || (s_reg == '0)) begin
            q_next = '0;
        end else if (r > RW'(Q_MAX)) begin
            q_next = DATA_WIDTH'(Q_MAX);
        end else begin
            q_next = r[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s_reg     <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            s1_valid  <= in_valid;
            s_reg     <= $signed({acc[ACC_WIDTH-1], acc})
                       + $signed({{(ACC_WIDTH + 1 - BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias});
            out_valid <= s1_valid;
            q         <= q_next;
        end
    end
endmodule

// File: rtl/fc_output_quantizer.sv
// FC output post-processing: requantizes each neuron result and packs PACK_NUM of them
// per SRAM write word in the layout the next layer reads.
module fc_output_quantizer
    import fc_output_quantizer_pkg::*;
(
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           num_out,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [4:0]                     quant_shift,
    input  logic                           acc_valid,
    input  logic signed [ACC_WIDTH-1:0]    acc_data,
    input  logic signed [BIAS_WIDTH-1:0]   bias_data,
    output logic                           sram_we,
    output logic [ADDR_WIDTH-1:0]          sram_waddr,
    output logic [PACK_NUM*DATA_WIDTH-1:0] sram_wdata,
    output logic [PACK_NUM-1:0]            sram_bytemask,
    output logic                           busy,
    output logic                           done,
    output state_t                         fsm_state
);
    state_t                         state;
    logic [CNT_WIDTH-1:0]           num_q;
    logic [CNT_WIDTH-1:0]           acc_cnt;
    logic [ADDR_WIDTH-1:0]          addr;
    logic [4:0]                     shift_q;
    logic [SLOT_W-1:0]              slot_cnt;
    logic [PACK_NUM*DATA_WIDTH-1:0] pack_buf;
    logic [PACK_NUM*DATA_WIDTH-1:0] buf_next;
    logic                           in_valid;
    logic                           s1_valid;
    logic                           q_valid;
    logic [DATA_WIDTH-1:0]          q;

    assign fsm_state = state;
    // Pulses past num_out and anything outside RUN never enter the pipeline.
    assign in_valid  = acc_valid && (state == RUN) && (acc_cnt != num_q);

    fc_requant u_requant (
        .clk       (clk),
        .srst      (srst),
        .in_valid  (in_valid),
        .acc       (acc_data),
        .bias      (bias_data),
        .shift     (shift_q),
        .s1_valid  (s1_valid),
        .out_valid (q_valid),
        .q         (q)
    );

    always_comb begin
        buf_next = pack_buf;
        buf_next[(PACK_NUM - 1 - int'(slot_cnt)) * DATA_WIDTH +: DATA_WIDTH] = q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state         <= IDLE;
            num_q         <= '0;
            acc_cnt       <= '0;
            addr          <= '0;
            shift_q       <= '0;
            slot_cnt      <= '0;
            pack_buf      <= '0;
            sram_we       <= 1'b0;
            sram_waddr    <= '0;
            sram_wdata    <= '0;
            sram_bytemask <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            sram_we       <= 1'b0;
            sram_wdata    <= '0;
            sram_bytemask <= '0;
            done          <= 1'b0;

            if (q_valid) begin
                if (slot_cnt == SLOT_W'(PACK_NUM - 1)) begin
                    sram_we       <= 1'b1;
                    sram_waddr    <= addr;
                    sram_wdata    <= buf_next;
                    sram_bytemask <= '1;
                    addr          <= addr + 1'b1;
                    slot_cnt      <= '0;
                    pack_buf      <= '0;
                end else begin
                    pack_buf <= buf_next;
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end

            if (in_valid) begin
                acc_cnt <= acc_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        num_q    <= num_out;
                        addr     <= base_addr;
                        shift_q  <= quant_shift;
                        acc_cnt  <= '0;
                        slot_cnt <= '0;
                        pack_buf <= '0;
                        busy     <= 1'b1;
                        if (num_out == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // All results accepted and both pipeline stages drained.
                    if ((acc_cnt == num_q) && !s1_valid && !q_valid) begin
                        state <= FLUSH;
                        if (slot_cnt != '0) begin
                            sram_we       <= 1'b1;
                            sram_waddr    <= addr;
                            sram_wdata    <= pack_buf;
                            sram_bytemask <= ~({PACK_NUM{1'b1}} >> slot_cnt);
                        end
                    end
                end
                FLUSH: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    slot_cnt <= '0;
                    pack_buf <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_output_quantizer.sv
// Directed bench for fc_output_quantizer: expected SRAM words are queued by the stimulus
// and checked by an independent monitor whenever the DUT writes.
module tb_fc_output_quantizer;
    import fc_output_quantizer_pkg::*;

    localparam int PW = PACK_NUM * DATA_WIDTH;
    localparam int WB = ADDR_WIDTH + PW + PACK_NUM;

    logic                         clk = 1'b0;
    logic                         srst;
    logic                         start;
    logic [CNT_WIDTH-1:0]         num_out;
    logic [ADDR_WIDTH-1:0]        base_addr;
    logic [4:0]                   quant_shift;
    logic                         acc_valid;
    logic signed [ACC_WIDTH-1:0]  acc_data;
    logic signed [BIAS_WIDTH-1:0] bias_data;
    logic                         sram_we;
    logic [ADDR_WIDTH-1:0]        sram_waddr;
    logic [PW-1:0]                sram_wdata;
    logic [PACK_NUM-1:0]          sram_bytemask;
    logic                         busy;
    logic                         done;
    state_t                       fsm_state;

    logic [WB-1:0] exp_q[$];
    int            slot_vals[PACK_NUM];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_we_cyc = 0;
    int            done_base = 0;

    fc_output_quantizer dut (
        .clk           (clk),
        .srst          (srst),
        .start         (start),
        .num_out       (num_out),
        .base_addr     (base_addr),
        .quant_shift   (quant_shift),
        .acc_valid     (acc_valid),
        .acc_data      (acc_data),
        .bias_data     (bias_data),
        .sram_we       (sram_we),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .sram_bytemask (sram_bytemask),
        .busy          (busy),
        .done          (done),
        .fsm_state     (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!srst) begin
            if (sram_we) begin
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d mask %h expected no write",
                             sram_waddr, sram_bytemask);
                end else begin
                    check("write", {sram_waddr, sram_wdata, sram_bytemask}, exp_q.pop_front());
                end
            end else begin
                check("idle_zero", WB'({sram_wdata, sram_bytemask}), '0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Driver tasks
    task automatic push_word(input int addr, input int n);
        logic [PW-1:0]       d;
        logic [PACK_NUM-1:0] m;
        d = '0;
        m = '0;
        for (int i = 0; i < n; i++) begin
            d[(PACK_NUM - 1 - i) * DATA_WIDTH +: DATA_WIDTH] = slot_vals[i][DATA_WIDTH-1:0];
            m[PACK_NUM - 1 - i] = 1'b1;
        end
        exp_q.push_back({ADDR_WIDTH'(addr), d, m});
    endtask

    task automatic start_layer(input int n, input int base, input int sh);
        done_base   = done_cnt;
        start       = 1'b1;
        num_out     = CNT_WIDTH'(n);
        base_addr   = ADDR_WIDTH'(base);
        quant_shift = 5'(sh);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int a, input int b);
        acc_valid = 1'b1;
        acc_data  = ACC_WIDTH'(a);
        bias_data = BIAS_WIDTH'(b);
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && done_cnt == done_base; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("done_count", WB'(done_cnt - done_base), WB'(1));
        check("writes_pending", WB'(exp_q.size()), '0);
        check("busy_after", WB'(busy), '0);
    endtask

    task automatic run_case2(input int base);
        for (int i = 0; i < PACK_NUM; i++) slot_vals[i] = i + 1;
        push_word(base, PACK_NUM);
        start_layer(PACK_NUM, base, 0);
        for (int i = 1; i <= PACK_NUM; i++) send(i, 0);
        wait_done();
        check("done_latency", WB'(done_cyc - last_we_cyc), WB'(2));
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; num_out = '0; base_addr = '0; quant_shift = '0;
        acc_valid = 1'b0; acc_data = '0; bias_data = '0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("reset_we", WB'(sram_we), '0);
        check("reset_waddr", WB'(sram_waddr), '0);
        check("reset_busy_done", WB'({busy, done}), '0);
        check("reset_state", WB'(fsm_state), WB'(IDLE));
        @(posedge clk); #1;

        // Requant values: bias add, rounding, saturation, ReLU, zero sum, round down
        slot_vals[0] = 124; slot_vals[1] = 127; slot_vals[2] = 0;
        slot_vals[3] = 0;   slot_vals[4] = 1;
        push_word(100, 5);
        start_layer(5, 100, 3);
        check("busy_run", WB'({busy, fsm_state}), WB'({1'b1, RUN}));
        send(1000, -8); send(2000, 0); send(-50, 10); send(5, -5); send(11, 0);
        wait_done();

        // One full word, done two cycles after the write
        run_case2(5);

        // Full word plus partial word, shift 4 with rounding
        start_layer(25, 0, 4);
        for (int i = 0; i < PACK_NUM; i++) slot_vals[i] = i + 1;
        push_word(0, PACK_NUM);
        for (int i = 0; i < 5; i++) slot_vals[i] = 21 + i;
        push_word(1, 5);
        for (int i = 1; i <= 25; i++) send(16 * i, -8);
        wait_done();

        // Empty layer
        start_layer(0, 3, 0);
        @(negedge clk);
        check("empty_done", WB'({done, busy, fsm_state}), WB'({1'b1, 1'b1, DONE}));
        @(negedge clk);
        check("empty_idle", WB'({done, busy, fsm_state}), WB'({1'b0, 1'b0, IDLE}));
        wait_done();

        // Reset mid-layer aborts; then a fresh layer works
        start_layer(20, 9, 0);
        for (int i = 1; i <= 7; i++) send(i, 0);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check("abort_outputs", WB'({sram_we, busy, done, fsm_state}), '0);
        repeat (10) @(negedge clk);
        check("abort_no_done", WB'(done_cnt - done_base), '0);
        @(posedge clk); #1;
        run_case2(5);

        // start during RUN and a 21st valid are ignored
        for (int i = 0; i < PACK_NUM; i++) slot_vals[i] = i + 1;
        push_word(12, PACK_NUM);
        start_layer(20, 12, 0);
        for (int i = 1; i <= 10; i++) send(i, 0);
        start = 1'b1; num_out = 10'd3; base_addr = 10'd40;
        send(11, 0);
        start = 1'b0;
        for (int i = 12; i <= 21; i++) send(i, 0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1);
    end
endmodule
